// File: rtl/ramasync_bist.sv
// March C- self-test engine for a single-port RAM with asynchronous read.
// Drives the RAM port from registered state and checks read data in the same cycle.
module ramasync_bist #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [2:0]    fail_elem,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_data
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic {PH_READ, PH_WRITE} phase_t;

    localparam logic [AW-1:0] ADDR_LAST = '1;
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

    state_t        r_state;
    phase_t        r_phase;
    logic [2:0]    r_elem;
    logic [AW-1:0] r_addr;
    logic          r_fail;
    logic [2:0]    r_fail_elem;
    logic [AW-1:0] r_fail_addr;
    logic [DW-1:0] r_fail_data;

    logic          w_wonly;
    logic          w_ronly;
    logic          w_desc;
    logic          w_is_read;
    logic          w_last_op;
    logic          w_at_end;
    logic          w_mismatch;
    logic [2:0]    w_next_elem;
    logic [DW-1:0] w_pattern;
    logic [DW-1:0] w_expect;

    always_comb begin
        w_wonly     = (r_elem == 3'd0);
        w_ronly     = (r_elem == 3'd5);
        w_desc      = (r_elem == 3'd3) || (r_elem == 3'd4);
        w_is_read   = !w_wonly && (w_ronly || (r_phase == PH_READ));
        w_last_op   = w_wonly || w_ronly || (r_phase == PH_WRITE);
        w_at_end    = w_desc ? (r_addr == '0) : (r_addr == ADDR_LAST);
        w_next_elem = r_elem + 3'd1;
        w_pattern   = ((r_elem == 3'd1) || (r_elem == 3'd3)) ? '1 : '0;
        w_expect    = ((r_elem == 3'd2) || (r_elem == 3'd4)) ? '1 : '0;
        // Case inequality so an X/Z read word is reported as a fault.
        w_mismatch  = w_is_read && (mem_dout !== w_expect);
    end

    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign mem_we    = busy && !w_is_read;
    assign mem_addr  = busy ? r_addr : '0;
    assign mem_din   = busy ? w_pattern : '0;
    assign fail      = r_fail;
    assign fail_elem = r_fail_elem;
    assign fail_addr = r_fail_addr;
    assign fail_data = r_fail_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_phase     <= PH_READ;
            r_elem      <= '0;
            r_addr      <= '0;
            r_fail      <= 1'b0;
            r_fail_elem <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_RUN;
                        r_phase     <= PH_READ;
                        r_elem      <= '0;
                        r_addr      <= '0;
                        r_fail      <= 1'b0;
                        r_fail_elem <= '0;
                        r_fail_addr <= '0;
                        r_fail_data <= '0;
                    end
                end
                S_RUN: begin
                    if (w_mismatch) begin
                        r_fail      <= 1'b1;
                        r_fail_elem <= r_elem;
                        r_fail_addr <= r_addr;
                        r_fail_data <= mem_dout;
                        r_state     <= S_DONE;
                    end else if (!w_last_op) begin
                        r_phase <= PH_WRITE;
                    end else begin
                        r_phase <= PH_READ;
                        if (!w_at_end) begin
                            r_addr <= w_desc ? (r_addr - ADDR_ONE) : (r_addr + ADDR_ONE);
                        end else if (w_ronly) begin
                            r_state <= S_DONE;
                        end else begin
                            r_elem <= w_next_elem;
                            r_addr <= ((w_next_elem == 3'd3) || (w_next_elem == 3'd4)) ? ADDR_LAST : '0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ramasync_bist.sv
// Scoreboard bench for ramasync_bist: a March C- reference model over a small
// faulty RAM predicts every RAM operation and the final verdict.
module tb_ramasync_bist;
    localparam int DW = 8;
    localparam int AW = 2;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic          busy;
    logic          done;
    logic          fail;
    logic [2:0]    fail_elem;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;

    ramasync_bist #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .busy(busy), .done(done), .fail(fail),
        .fail_elem(fail_elem), .fail_addr(fail_addr), .fail_data(fail_data)
    );

    always #5 clk = ~clk;

    typedef struct {logic we; logic [AW-1:0] addr; logic [DW-1:0] din;} op_t;
    typedef struct {logic fl; logic [2:0] elem; logic [AW-1:0] addr; logic [DW-1:0] data;} res_t;

    op_t  exp_ops[$];
    res_t exp_res[$];
    op_t  op_log[$];
    op_t  mon_op;
    res_t mon_res;

    int n_tests = 0;
    int n_fail  = 0;
    int busy_cnt = 0;
    int we_cnt   = 0;
    logic done_q = 1'b0;

    // Fault kinds: 0 none, 1 bit stuck at 0 on read, 2 writes ignored at one address.
    int fault_kind = 0;
    int fault_addr = 0;
    int fault_bit  = 0;
    logic [DW-1:0] ram [N];
    logic          load_req = 1'b0;
    logic [DW-1:0] fill_val = '0;

    function automatic logic [DW-1:0] fault_view(input int a, input logic [DW-1:0] v);
        if (fault_kind == 1 && a == fault_addr) return v & ~(8'h01 << fault_bit);
        return v;
    endfunction

    always_comb mem_dout = fault_view(int'(mem_addr), ram[mem_addr]);

    always @(posedge clk) begin
        if (load_req) begin
            for (int a = 0; a < N; a++) ram[a] <= fill_val;
        end else if (mem_we && !(fault_kind == 2 && int'(mem_addr) == fault_addr)) begin
            ram[mem_addr] <= mem_din;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    // Reference: walk the March C- element table over a model memory.
    task automatic model_run();
        logic [DW-1:0] m [N];
        int rd_exp [6] = '{-1, 0, 1, 0, 1, 0};
        int wr_val [6] = '{0, 1, 0, 1, 0, -1};
        int a;
        logic [DW-1:0] want;
        logic [DW-1:0] got;
        logic [DW-1:0] wv;
        logic [2:0]    e3;
        for (int i = 0; i < N; i++) m[i] = ram[i];
        for (int e = 0; e < 6; e++) begin
            e3 = e[2:0];
            for (int k = 0; k < N; k++) begin
                a = (e == 3 || e == 4) ? (N - 1 - k) : k;
                if (rd_exp[e] >= 0) begin
                    want = (rd_exp[e] == 1) ? 8'hFF : 8'h00;
                    got  = fault_view(a, m[a]);
                    exp_ops.push_back('{we: 1'b0, addr: a[AW-1:0], din: 8'h00});
                    if (got !== want) begin
                        exp_res.push_back('{fl: 1'b1, elem: e3, addr: a[AW-1:0], data: got});
                        return;
                    end
                end
                if (wr_val[e] >= 0) begin
                    wv = (wr_val[e] == 1) ? 8'hFF : 8'h00;
                    exp_ops.push_back('{we: 1'b1, addr: a[AW-1:0], din: wv});
                    if (!(fault_kind == 2 && a == fault_addr)) m[a] = wv;
                end
            end
        end
        exp_res.push_back('{fl: 1'b0, elem: 3'd0, addr: '0, data: '0});
    endtask

    always @(negedge clk) begin
        if (busy) begin
            busy_cnt++;
            if (mem_we) we_cnt++;
            op_log.push_back('{we: mem_we, addr: mem_addr, din: mem_din});
            chk("busy_done_excl", done, 0);
            if (exp_ops.size() == 0) flag("extra_op");
            else begin
                mon_op = exp_ops.pop_front();
                chk("op_we", mem_we, mon_op.we);
                chk("op_addr", mem_addr, mon_op.addr);
                if (mon_op.we) chk("op_din", mem_din, mon_op.din);
            end
        end else begin
            chk("idle_we", mem_we, 0);
        end
        if (done && !done_q) begin
            if (exp_res.size() == 0) flag("extra_done");
            else begin
                mon_res = exp_res.pop_front();
                chk("res_fail", fail, mon_res.fl);
                chk("res_elem", fail_elem, mon_res.elem);
                chk("res_addr", fail_addr, mon_res.addr);
                chk("res_data", fail_data, mon_res.data);
            end
        end
        done_q = done;
    end

    task automatic setup(input int kind, input int fa, input int fb, input logic [DW-1:0] fill);
        fault_kind = kind;
        fault_addr = fa;
        fault_bit  = fb;
        fill_val   = fill;
        load_req   = 1'b1;
        @(posedge clk); #1;
        load_req   = 1'b0;
    endtask

    task automatic do_run(input bit noisy);
        int n_ops;
        bit got_done;
        model_run();
        n_ops = exp_ops.size();
        busy_cnt = 0;
        we_cnt = 0;
        op_log.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("entry_busy", busy, 1);
        chk("entry_done", done, 0);
        chk("entry_fail", fail, 0);
        chk("entry_felem", fail_elem, 0);
        chk("entry_faddr", fail_addr, 0);
        chk("entry_fdata", fail_data, 0);
        got_done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            start = (noisy && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (!got_done) flag("done_timeout");
        @(negedge clk); #1;
        chk("busy_cycles", busy_cnt, n_ops);
        chk("ops_left", exp_ops.size(), 0);
        chk("res_left", exp_res.size(), 0);
        chk("done_addr", mem_addr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e3_addr [8];
        logic [7:0] e0_addr [4];
        e3_addr = '{8'd3, 8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0};
        e0_addr = '{8'd0, 8'd1, 8'd2, 8'd3};
        rst = 1'b1;
        start = 1'b0;
        setup(0, 0, 0, 8'h00);
        @(posedge clk); @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_din", mem_din, 0);
        chk("rst_felem", fail_elem, 0);
        chk("rst_faddr", fail_addr, 0);
        chk("rst_fdata", fail_data, 0);
        rst = 1'b0;
        #1;

        // Clean run with explicit cycle counts and address order.
        setup(0, 0, 0, 8'h00);
        do_run(1'b0);
        chk("clean_busy40", busy_cnt, 40);
        chk("clean_we20", we_cnt, 20);
        chk("clean_done", done, 1);
        chk("clean_fail", fail, 0);
        for (int a = 0; a < N; a++) chk("clean_ram", ram[a], 0);
        if (op_log.size() >= 28) begin
            for (int i = 0; i < 4; i++) chk("e0_addr", op_log[i].addr, e0_addr[i][1:0]);
            for (int i = 0; i < 8; i++) begin
                chk("e3_addr", op_log[20 + i].addr, e3_addr[i][1:0]);
                chk("e3_we", op_log[20 + i].we, i % 2);
                if (i % 2 == 1) chk("e3_din", op_log[20 + i].din, 8'hFF);
            end
        end else flag("clean_log_short");

        // Stuck-at-0 on bit0 of addr 2.
        setup(1, 2, 0, 8'h00);
        do_run(1'b0);
        chk("stuck_done", done, 1);
        chk("stuck_fail", fail, 1);
        chk("stuck_elem", fail_elem, 2);
        chk("stuck_addr", fail_addr, 2);
        chk("stuck_data", fail_data, 8'hFE);
        if (op_log.size() > 0) chk("stuck_last_we", op_log[op_log.size() - 1].we, 0);
        else flag("stuck_log_empty");

        // Restart from a failed DONE with the fault removed, noisy start during RUN.
        setup(0, 0, 0, 8'h00);
        do_run(1'b1);
        chk("rerun_busy40", busy_cnt, 40);
        chk("rerun_fail", fail, 0);

        // Dropped writes at addr 3 with RAM pre-filled to 0xFF.
        setup(2, 3, 0, 8'hFF);
        do_run(1'b0);
        chk("drop_fail", fail, 1);
        chk("drop_elem", fail_elem, 1);
        chk("drop_addr", fail_addr, 3);
        chk("drop_data", fail_data, 8'hFF);

        // Reset asserted during element 2.
        setup(0, 0, 0, 8'h00);
        model_run();
        busy_cnt = 0;
        op_log.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 100 && busy_cnt < 14; c++) begin
            @(posedge clk); #1;
        end
        chk("rst_mid_reached", busy_cnt >= 14, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ops.delete();
        exp_res.delete();
        @(negedge clk); #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        chk("rstmid_fail", fail, 0);
        chk("rstmid_we", mem_we, 0);
        do_run(1'b0);
        chk("after_rst_busy40", busy_cnt, 40);
        chk("after_rst_fail", fail, 0);

        // Randomised fault injection against the model.
        for (int r = 0; r < 10; r++) begin
            setup(int'($urandom_range(0, 2)), int'($urandom_range(0, N - 1)),
                  int'($urandom_range(0, DW - 1)), 8'($urandom));
            do_run(1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
